// File: rtl/mmv_swu_ram_reader.sv
// mmv_swu_ram_reader: read-side sequencer for the sliding-window unit's asymmetric buffer RAM.
// Ports:
//   ap_clk, ap_rst_n   clock, asynchronous active-low reset
//   wr_commit          in : writer finished one wide word (RATIO elements)
//   rd_release         out: one wide-word slot has been fully read and may be reused
//   addrB, enaB, doB   RAM B-port read address, read strobe, read data (one-cycle latency)
//   out_tdata/tvalid/tready  element stream to downstream
//   err_overflow       out: sticky, commit arrived without room for RATIO elements
module mmv_swu_ram_reader #(
    parameter int WIDTHB     = 4,
    parameter int SIZEB      = 1024,
    parameter int ADDRWIDTHB = 10,
    parameter int RATIO      = 4
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  wr_commit,
    output logic                  rd_release,
    output logic [ADDRWIDTHB-1:0] addrB,
    output logic                  enaB,
    input  logic [WIDTHB-1:0]     doB,
    output logic [WIDTHB-1:0]     out_tdata,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic                  err_overflow
);
    localparam int CW = ADDRWIDTHB + 1;
    localparam int RW = RATIO > 1 ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] FULL = CW'(SIZEB);
    localparam logic [CW-1:0] ROOM = CW'(SIZEB - RATIO);
    localparam logic [CW-1:0] STEP = CW'(RATIO);
    localparam logic [ADDRWIDTHB-1:0] LAST = ADDRWIDTHB'(SIZEB - 1);
    localparam logic [RW-1:0] RLAST = RW'(RATIO - 1);

    logic [CW-1:0]         avail, availNext;
    logic [ADDRWIDTHB-1:0] rdPtr;
    logic                  inflight;
    logic [1:0]            bufCount;
    logic [WIDTHB-1:0]     head, tail;
    logic [RW-1:0]         relCnt;
    logic                  pop, push, issue, overflow;

    always_comb begin
        pop = out_tvalid & out_tready;
        push = inflight;
        // a new read may only launch if, after this cycle's pop, the buffer can still take its data
        issue = (avail != '0) && (({1'b0, bufCount} + 3'(inflight)) <= (3'd1 + 3'(pop)));
        overflow = wr_commit && (avail > ROOM);
        availNext = overflow ? FULL : avail + (wr_commit ? STEP : '0) - CW'(issue);
    end

    assign enaB = issue;
    assign addrB = rdPtr;
    assign out_tvalid = bufCount != 2'd0;
    assign out_tdata = head;
    assign rd_release = push && (relCnt == RLAST);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            avail <= '0;
            rdPtr <= '0;
            inflight <= 1'b0;
            bufCount <= '0;
            head <= '0;
            tail <= '0;
            relCnt <= '0;
            err_overflow <= 1'b0;
        end else begin
            avail <= availNext;
            inflight <= issue;
            err_overflow <= err_overflow | overflow;
            bufCount <= bufCount + 2'(push) - 2'(pop);
            if (issue) rdPtr <= (rdPtr == LAST) ? '0 : rdPtr + ADDRWIDTHB'(1);
            if (push) relCnt <= (relCnt == RLAST) ? '0 : relCnt + RW'(1);
            // head is always the oldest entry; tail only ever holds the second one
            if (pop && bufCount == 2'd2) head <= tail;
            else if (push && (bufCount == 2'd0 || pop)) head <= doB;
            if (push && (bufCount == 2'd2 || (bufCount == 2'd1 && !pop))) tail <= doB;
        end
    end
endmodule

// File: tb/tb_mmv_swu_ram_reader.sv
// tb_mmv_swu_ram_reader: directed self-checking bench for mmv_swu_ram_reader (SIZEB=16, RATIO=4).
module tb_mmv_swu_ram_reader;
    logic       ap_clk = 1'b0;
    logic       ap_rst_n, wr_commit, rd_release, enaB, out_tvalid, out_tready, err_overflow;
    logic [3:0] addrB;
    logic [7:0] doB, out_tdata;
    logic [7:0] ram [16];
    int         checks = 0;
    int         errors = 0;

    int eEna [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
    int eAddr[8] = '{0, 0, 1, 2, 3, 4, 4, 4};
    int eVld [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    int eRel [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    int bpReady[4] = '{1, 0, 0, 1};

    mmv_swu_ram_reader #(.WIDTHB(8), .SIZEB(16), .ADDRWIDTHB(4), .RATIO(4)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .wr_commit(wr_commit), .rd_release(rd_release),
        .addrB(addrB), .enaB(enaB), .doB(doB), .out_tdata(out_tdata), .out_tvalid(out_tvalid),
        .out_tready(out_tready), .err_overflow(err_overflow)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) if (enaB) doB <= ram[addrB];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic c, input logic r);
        @(posedge ap_clk);
        #1;
        wr_commit = c;
        out_tready = r;
        #1;
    endtask

    task automatic chkIdle(input string tag);
        chk({tag, "_addrB"}, addrB, 0);
        chk({tag, "_enaB"}, enaB, 0);
        chk({tag, "_tvalid"}, out_tvalid, 0);
        chk({tag, "_tdata"}, out_tdata, 0);
        chk({tag, "_release"}, rd_release, 0);
        chk({tag, "_ovf"}, err_overflow, 0);
    endtask

    initial begin
        int issued, popped, rels, outstanding;
        logic pop;
        ap_rst_n = 1'b0;
        wr_commit = 1'b0;
        out_tready = 1'b0;
        for (int i = 0; i < 16; i++) ram[i] = 8'(i + 1);
        repeat (2) @(posedge ap_clk);
        #2;
        chkIdle("reset");
        ap_rst_n = 1'b1;

        // single commit, free-running sink
        for (int k = 0; k < 8; k++) begin
            cyc(k == 0, 1'b1);
            chk("single_enaB", enaB, eEna[k]);
            chk("single_addrB", addrB, eAddr[k]);
            chk("single_tvalid", out_tvalid, eVld[k]);
            chk("single_release", rd_release, eRel[k]);
            if (eVld[k] != 0) chk("single_tdata", out_tdata, k - 2);
        end

        // commit lands in the same cycle as the issue that drains avail to zero
        for (int k = 0; k < 13; k++) begin
            cyc(k == 0 || k == 4, 1'b1);
            chk("simul_enaB", enaB, (k >= 1 && k <= 8));
            if (k >= 1 && k <= 8) chk("simul_addrB", addrB, 4 + k - 1);
            chk("simul_tvalid", out_tvalid, (k >= 3 && k <= 10));
            if (k >= 3 && k <= 10) chk("simul_tdata", out_tdata, k + 2);
            chk("simul_release", rd_release, (k == 5 || k == 9));
        end

        // backpressure with ready pattern 1,0,0,1; reads cross the wrap at 15 -> 0
        issued = 0;
        popped = 0;
        for (int k = 0; k < 48; k++) begin
            cyc(k < 3, bpReady[k % 4] != 0);
            pop = out_tvalid & out_tready;
            outstanding = issued - popped;
            chk("bp_capacity", outstanding <= 2, 1);
            if (outstanding == 2 && !pop) chk("bp_hold_enaB", enaB, 0);
            if (enaB) begin
                chk("bp_addrB", addrB, (12 + issued) % 16);
                issued++;
            end
            if (pop) begin
                chk("bp_tdata", out_tdata, ((12 + popped) % 16) + 1);
                popped++;
            end
        end
        chk("bp_popped", popped, 12);
        chk("bp_issued", issued, 12);
        chk("bp_drained", out_tvalid, 0);

        // eight spaced commits: 32 back-to-back reads through two wraps with no bubble
        rels = 0;
        for (int k = 0; k < 36; k++) begin
            cyc((k % 4 == 0) && k < 32, 1'b1);
            chk("wrap_enaB", enaB, (k >= 1 && k <= 32));
            if (k >= 1 && k <= 32) chk("wrap_addrB", addrB, (8 + k - 1) % 16);
            chk("wrap_tvalid", out_tvalid, (k >= 3 && k <= 34));
            if (k >= 3 && k <= 34) chk("wrap_tdata", out_tdata, ((8 + k - 3) % 16) + 1);
            chk("wrap_release", rd_release, (k >= 5 && k <= 33 && (k - 5) % 4 == 0));
            if (rd_release) rels++;
        end
        chk("wrap_release_count", rels, 8);
        chk("wrap_no_ovf", err_overflow, 0);

        // overflow: sink stalled, fifth commit finds avail=14 > 12
        for (int k = 0; k < 8; k++) begin
            cyc(k <= 4, 1'b0);
            chk("ovf_flag", err_overflow, k >= 5);
            chk("ovf_enaB", enaB, (k == 1 || k == 2));
            if (k == 1 || k == 2) chk("ovf_addrB", addrB, 8 + k - 1);
            if (k >= 3) begin
                chk("ovf_tvalid", out_tvalid, 1);
                chk("ovf_tdata_held", out_tdata, 9);
            end
        end

        // one pop frees room for one read, leaving data buffered and a read in flight
        cyc(1'b0, 1'b1);
        chk("pre_rst_tdata", out_tdata, 9);
        chk("pre_rst_enaB", enaB, 1);
        chk("pre_rst_addrB", addrB, 10);
        cyc(1'b0, 1'b0);
        chk("pre_rst_tvalid", out_tvalid, 1);
        chk("pre_rst_ovf", err_overflow, 1);
        #1;
        ap_rst_n = 1'b0;
        #1;
        chkIdle("async_rst");
        @(posedge ap_clk);
        #3;
        ap_rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b1);
            chk("post_rst_tvalid", out_tvalid, 0);
            chk("post_rst_enaB", enaB, 0);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(k == 0, 1'b1);
            chk("restart_enaB", enaB, k >= 1);
            chk("restart_addrB", addrB, k >= 1 ? k - 1 : 0);
            chk("restart_tvalid", out_tvalid, k == 3);
        end
        chk("restart_tdata", out_tdata, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
